muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for RV32M MUL/DIV/REM ops issued from the execute stage.
//  - Accepts resolved operands (after forwarding) from execute.
//  - Runs an iterative shift-add multiplier or a restoring divider.
//  - Stalls the front of the pipeline while busy; returns one result pulse to the EX/MEM path.

---
 rtl/muldiv_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiplier and restoring divider
// sharing one accumulator, with an optional one-cycle path for divide special cases.
module muldiv_sequencer #(
  parameter int unsigned XLEN         = 32,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;

  logic [1:0]      state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [CntW-1:0] count_q, count_d;
  // hi holds the product high half / partial remainder; lo holds multiplier / quotient.
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            b_zero, sgn_ovf, fast, neg_start;

  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, final_res;

  always_comb begin
    a_signed = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    b_signed = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    a_neg    = a_signed && operand_a[XLEN-1];
    b_neg    = b_signed && operand_b[XLEN-1];
    abs_a    = a_neg ? -operand_a : operand_a;
    abs_b    = b_neg ? -operand_b : operand_b;
    b_zero   = (operand_b == '0);
    sgn_ovf  = ((op == OpDiv) || (op == OpRem)) &&
               (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (&operand_b);
    fast     = FAST_SPECIAL && op[2] && (b_zero || sgn_ovf);
    case (op)
      OpMulh:   neg_start = a_neg ^ b_neg;
      OpMulhsu: neg_start = a_neg;
      // Divide-by-zero quotient is all ones regardless of dividend sign.
      OpDiv:    neg_start = (a_neg ^ b_neg) && !b_zero;
      OpRem:    neg_start = a_neg;
      default:  neg_start = 1'b0;
    endcase
  end

  always_comb begin
    mul_sum   = hi_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod      = {hi_q[XLEN-1:0], lo_q};
    prod_fix  = neg_q ? -prod : prod;
    quo_fix   = neg_q ? -lo_q : lo_q;
    rem_fix   = neg_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];
    case (op_q)
      OpMul:                    final_res = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: final_res = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:            final_res = quo_fix;
      default:                  final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d    = op;
          neg_d   = neg_start;
          count_d = CntW'(XLEN - 1);
          hi_d    = '0;
          if (op[2]) begin
            opnd_d  = abs_b;
            lo_d    = abs_a;
            state_d = StBusy;
            // Preload the accumulator so DONE's normal result selection yields the answer.
            if (fast) begin
              state_d = StDone;
              if (b_zero) begin
                hi_d = {1'b0, abs_a};
                lo_d = '1;
              end
            end
          end else begin
            opnd_d  = abs_a;
            lo_d    = abs_b;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
              hi_d = div_diff;
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = div_shift;
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = {1'b0, mul_sum[XLEN:1]};
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          count_d = count_q - 1'b1;
          if (count_q == '0) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!flush) res_d = final_res;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    busy         = (state_q != StIdle);
    stall        = !flush && (((state_q == StIdle) && start) || (state_q == StBusy));
    result_valid = (state_q == StDone) && !flush;
    result       = result_valid ? final_res : res_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, special cases, flush and reset.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  muldiv_sequencer #(
    .XLEN        (32),
    .FAST_SPECIAL(1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .result_valid(result_valid),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for its result, check latency/value/stall, then step once more.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        output int done_cyc);
    int lat;
    bit seen;
    bit stall_ok;
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    #1;
    chk({tag, "/stall_at_start"}, {31'b0, stall}, 32'd1);
    step();
    start     = 1'b0;
    op        = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    lat       = 1;
    seen      = 1'b0;
    stall_ok  = 1'b1;
    while (lat <= 40 && !seen) begin
      if (result_valid) begin
        seen = 1'b1;
      end else begin
        if (!stall) stall_ok = 1'b0;
        step();
        lat++;
      end
    end
    done_cyc = cyc;
    chk({tag, "/valid_seen"}, {31'b0, seen}, 32'd1);
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/result"}, result, exp);
    chk({tag, "/stall_low_at_done"}, {31'b0, stall}, 32'd0);
    chk({tag, "/stall_while_busy"}, {31'b0, stall_ok}, 32'd1);
    step();
    chk({tag, "/valid_pulse"}, {31'b0, result_valid}, 32'd0);
    chk({tag, "/result_held"}, result, exp);
  endtask

  initial begin
    int d1;
    int d2;
    int t0;
    reset     = 1'b1;
    start     = 1'b0;
    op        = 3'd0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    flush     = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("reset/stall", {31'b0, stall}, 32'd0);
    chk("reset/busy", {31'b0, busy}, 32'd0);
    chk("reset/valid", {31'b0, result_valid}, 32'd0);
    chk("reset/result", result, 32'd0);

    run_op("mul_7x6", 3'd0, 32'd7, 32'd6, 32'd42, 33, d1);
    run_op("mul_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33, d1);
    run_op("mulh_m1m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, d1);
    run_op("mulhu_m1m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, d1);
    run_op("mulhsu_m2x3", 3'd2, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33, d1);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, d1);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, d1);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33, d1);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33, d1);

    run_op("div_by_zero", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, d1);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, d1);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, d1);
    run_op("remu_by_zero", 3'd7, 32'd5, 32'd0, 32'd5, 1, d1);

    // Flush a DIVU at T+10; the previous result (5) must survive.
    t0        = cyc;
    op        = 3'd5;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    start     = 1'b1;
    step();
    start = 1'b0;
    while (cyc < t0 + 10) step();
    flush = 1'b1;
    #1;
    chk("flush/stall_same_cycle", {31'b0, stall}, 32'd0);
    chk("flush/no_valid", {31'b0, result_valid}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush/idle_next", {31'b0, busy}, 32'd0);
    chk("flush/no_valid_after", {31'b0, result_valid}, 32'd0);
    chk("flush/result_kept", result, 32'd5);
    step();
    run_op("after_flush_divu", 3'd5, 32'd100, 32'd7, 32'd14, 33, d1);

    // Flush together with start in IDLE: start is ignored.
    op    = 3'd0;
    start = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_start/stall", {31'b0, stall}, 32'd0);
    step();
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start/not_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of a MUL.
    t0        = cyc;
    op        = 3'd0;
    operand_a = 32'd11;
    operand_b = 32'd13;
    start     = 1'b1;
    step();
    start = 1'b0;
    while (cyc < t0 + 5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset/stall", {31'b0, stall}, 32'd0);
    chk("midreset/busy", {31'b0, busy}, 32'd0);
    chk("midreset/valid", {31'b0, result_valid}, 32'd0);
    chk("midreset/result", result, 32'd0);

    run_op("b2b_divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, 33, d1);
    run_op("b2b_mul_3x3", 3'd0, 32'd3, 32'd3, 32'd9, 33, d2);
    chk("b2b/spacing", 32'(d2 - d1), 32'd34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
